// File: rtl/obi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// obi_mem_arbiter
//   Simulation memory model: N OBI masters share one single-ported RAM through
//   a round-robin arbiter. Reads have a fixed, pipelined latency. Writes honour
//   per-byte enables. Two memory-mapped pseudo-peripherals report test status:
//     TEST_STATUS_ADDR : write 123456789 -> tests_passed_o, write 1 -> tests_failed_o
//     EXIT_ADDR        : write sets exit_value_o and exit_valid_o
//   Any other address outside the RAM returns err=1, rdata=0 and changes nothing.
//
// Optional feature macro: OBI_MEM_STALL_EN
//   When defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) runs
//   every cycle and grants are suppressed whenever lfsr[1:0] == 2'b00.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i   [N]          per-master request
//   gnt_o   [N]          per-master grant, combinational, one-hot or zero
//   addr_i  [N*32]       byte address, master k at [32k +: 32]
//   we_i    [N]          write enable
//   be_i    [N*4]        byte enables, master k at [4k +: 4]
//   wdata_i [N*32]       write data
//   rvalid_o[N]          response valid, RD_LATENCY cycles after grant
//   rdata_o [N*32]       response data (zero when not valid)
//   err_o   [N]          response error, qualified by rvalid_o
//   tests_passed_o       sticky pass flag
//   tests_failed_o       sticky fail flag
//   exit_value_o [32]    last value written to EXIT_ADDR
//   exit_valid_o         sticky, set on first EXIT_ADDR write
// -----------------------------------------------------------------------------
module obi_mem_arbiter #(
  parameter int unsigned N_MASTERS        = 3,
  parameter int unsigned DEPTH            = 4096,
  parameter int unsigned RD_LATENCY       = 1,
  parameter logic [31:0] TEST_STATUS_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR        = 32'h2000_0004
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_MASTERS-1:0]      req_i,
  output logic [N_MASTERS-1:0]      gnt_o,
  input  logic [N_MASTERS*32-1:0]   addr_i,
  input  logic [N_MASTERS-1:0]      we_i,
  input  logic [N_MASTERS*4-1:0]    be_i,
  input  logic [N_MASTERS*32-1:0]   wdata_i,
  output logic [N_MASTERS-1:0]      rvalid_o,
  output logic [N_MASTERS*32-1:0]   rdata_o,
  output logic [N_MASTERS-1:0]      err_o,
  output logic                      tests_passed_o,
  output logic                      tests_failed_o,
  output logic [31:0]               exit_value_o,
  output logic                      exit_valid_o
);

  localparam int unsigned IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] RAM_WORDS = 30'(DEPTH);
  localparam logic [31:0] PASS_CODE = 32'd123456789;
  localparam logic [31:0] FAIL_CODE = 32'd1;

  // Merge new write data into an existing word, one byte lane per enable bit.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Optional grant throttling
  // ---------------------------------------------------------------------------
`ifdef OBI_MEM_STALL_EN
  logic [15:0] lfsr;
  logic        stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic stall;
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage p0: arbitration and decode (combinational, grant cycle)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]     rr_ptr;   // first master searched this cycle
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [N_MASTERS-1:0] gnt;
  logic [31:0]          g_addr;
  logic [31:0]          g_wdata;
  logic                 g_we;
  logic [3:0]           g_be;

  // Two passes give the rotated priority: first masters at or above the
  // pointer, then the wrap-around masters below it.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_we    = 1'b0;
    g_be    = '0;
    if (!stall) begin
      for (int k = 0; k < int'(N_MASTERS); k++) begin
        if (!gnt_any && req_i[k] && (IDX_W'(k) >= rr_ptr)) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(k);
        end
      end
      for (int k = 0; k < int'(N_MASTERS); k++) begin
        if (!gnt_any && req_i[k]) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(k);
        end
      end
      for (int k = 0; k < int'(N_MASTERS); k++) begin
        if (gnt_any && (gnt_idx == IDX_W'(k))) begin
          gnt[k]  = 1'b1;
          g_addr  = addr_i[k*32 +: 32];
          g_wdata = wdata_i[k*32 +: 32];
          g_we    = we_i[k];
          g_be    = be_i[k*4 +: 4];
        end
      end
    end
  end

  assign gnt_o = gnt;

  logic          is_ram;
  logic          is_status;
  logic          is_exit;
  logic          is_err;
  logic [AW-1:0] widx;

  // RAM decode takes precedence should an MMIO address ever fall inside it.
  assign is_ram    = (g_addr[31:2] < RAM_WORDS);
  assign is_status = !is_ram && (g_addr == TEST_STATUS_ADDR);
  assign is_exit   = !is_ram && (g_addr == EXIT_ADDR);
  assign is_err    = !(is_ram || is_status || is_exit);
  assign widx      = g_addr[AW+1:2];

  // Round-robin pointer and MMIO state only move on an actual grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr         <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_value_o   <= '0;
      exit_valid_o   <= 1'b0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_idx + IDX_W'(1);
      if (g_we && is_status) begin
        if (g_wdata == PASS_CODE) tests_passed_o <= 1'b1;
        if (g_wdata == FAIL_CODE) tests_failed_o <= 1'b1;
      end
      if (g_we && is_exit) begin
        exit_value_o <= g_wdata;
        exit_valid_o <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stages p1..pN: response pipeline, RD_LATENCY registers deep
  // ---------------------------------------------------------------------------
  logic             vld_p  [RD_LATENCY];
  logic [IDX_W-1:0] id_p   [RD_LATENCY];
  logic             err_p  [RD_LATENCY];
  logic [31:0]      data_p [RD_LATENCY];
  logic [31:0]      mem    [DEPTH];

  // Control half of the pipeline: cleared by reset so in-flight responses die.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(RD_LATENCY); s++) begin
        vld_p[s] <= 1'b0;
        id_p[s]  <= '0;
        err_p[s] <= 1'b0;
      end
    end else begin
      vld_p[0] <= gnt_any;
      id_p[0]  <= gnt_idx;
      err_p[0] <= is_err;
      for (int s = 1; s < int'(RD_LATENCY); s++) begin
        vld_p[s] <= vld_p[s-1];
        id_p[s]  <= id_p[s-1];
        err_p[s] <= err_p[s-1];
      end
    end
  end

  // Storage and data half of the pipeline: never reset. Reads and writes
  // cannot coincide (single grant), so the synchronous read sees the word as
  // left by all earlier cycles.
  always_ff @(posedge clk_i) begin
    if (gnt_any && is_ram && g_we) mem[widx] <= be_merge(mem[widx], g_wdata, g_be);
    data_p[0] <= (gnt_any && is_ram && !g_we) ? mem[widx] : '0;
    for (int s = 1; s < int'(RD_LATENCY); s++) begin
      data_p[s] <= data_p[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: route the oldest response to its master
  // ---------------------------------------------------------------------------
  logic             vld_out;
  logic [IDX_W-1:0] id_out;
  logic             err_out;
  logic [31:0]      data_out;

  assign vld_out  = vld_p[RD_LATENCY-1];
  assign id_out   = id_p[RD_LATENCY-1];
  assign err_out  = err_p[RD_LATENCY-1];
  assign data_out = data_p[RD_LATENCY-1];

  // Data is gated by valid and by !err so reset alone forces rdata_o to zero.
  for (genvar k = 0; k < int'(N_MASTERS); k++) begin : g_rsp
    logic hit;
    assign hit                 = vld_out && (id_out == IDX_W'(k));
    assign rvalid_o[k]         = hit;
    assign err_o[k]            = hit && err_out;
    assign rdata_o[k*32 +: 32] = (hit && !err_out) ? data_out : 32'h0;
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;

  localparam int          N     = 3;
  localparam int          DEPTH = 1024;
  localparam int          RDL   = 2;
  localparam logic [31:0] TS    = 32'h2000_0000;
  localparam logic [31:0] EX    = 32'h2000_0004;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  gnt_o;
  logic [N*32-1:0] addr_i = '0;
  logic [N-1:0]  we_i = '0;
  logic [N*4-1:0] be_i = '0;
  logic [N*32-1:0] wdata_i = '0;
  logic [N-1:0]  rvalid_o;
  logic [N*32-1:0] rdata_o;
  logic [N-1:0]  err_o;
  logic          tests_passed_o;
  logic          tests_failed_o;
  logic [31:0]   exit_value_o;
  logic          exit_valid_o;

  obi_mem_arbiter #(
    .N_MASTERS(N), .DEPTH(DEPTH), .RD_LATENCY(RDL),
    .TEST_STATUS_ADDR(TS), .EXIT_ADDR(EX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
    .exit_value_o(exit_value_o), .exit_valid_o(exit_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: word-addressed memory with a "fully known" flag, the
  // MMIO flags, the next-search pointer and an in-order list of responses.
  typedef struct {
    int          due;
    int          m;
    bit          err;
    bit [31:0]   data;
    bit          known;
  } rsp_t;

  bit [31:0] mdl_mem [DEPTH];
  bit        mdl_ok  [DEPTH];
  rsp_t      q[$];
  int        rr = 0;
  int        cyc = 0;
  bit        m_pass = 0, m_fail = 0, m_exv = 0;
  bit [31:0] m_exit = 0;

  // Drive values for the next cycle.
  logic [N-1:0] d_req;
  logic [31:0]  d_addr  [N];
  logic         d_we    [N];
  logic [3:0]   d_be    [N];
  logic [31:0]  d_wdata [N];

  // Observations captured for the directed scenarios.
  logic [N-1:0] obs_gnt;
  logic [31:0]  obs_rdata [N];
  logic         obs_err   [N];
  logic         obs_vld   [N];

  task automatic set_idle();
    d_req = '0;
    for (int k = 0; k < N; k++) begin
      d_addr[k] = '0; d_we[k] = 1'b0; d_be[k] = 4'h0; d_wdata[k] = '0;
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < N; k++) begin
      obs_rdata[k] = 32'h5A5A_5A5A; obs_err[k] = 1'bx; obs_vld[k] = 1'b0;
    end
  endtask

  task automatic model_apply(input int g);
    rsp_t e;
    logic [31:0] a;
    int w;
    a = d_addr[g];
    e.due = cyc + RDL; e.m = g; e.err = 0; e.data = 0; e.known = 1;
    if (a < 32'(DEPTH * 4)) begin
      w = int'(a >> 2);
      if (d_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (d_be[g][b]) mdl_mem[w][8*b +: 8] = d_wdata[g][8*b +: 8];
        if (d_be[g] == 4'hF) mdl_ok[w] = 1;
      end else begin
        e.data  = mdl_mem[w];
        e.known = mdl_ok[w];
      end
    end else if (a == TS) begin
      if (d_we[g] && d_wdata[g] == 32'd123456789) m_pass = 1;
      else if (d_we[g] && d_wdata[g] == 32'd1) m_fail = 1;
    end else if (a == EX) begin
      if (d_we[g]) begin m_exit = d_wdata[g]; m_exv = 1; end
    end else begin
      e.err = 1;
    end
    q.push_back(e);
  endtask

  // One clock cycle: check responses/flags, drive inputs, check the grant.
  task automatic step();
    rsp_t e;
    bit have;
    logic [N-1:0] exp_v;
    int best, bestd;
    @(negedge clk_i);
    have  = (q.size() > 0) && (q[0].due == cyc);
    exp_v = '0;
    if (have) begin
      e = q.pop_front();
      exp_v = N'(1 << e.m);
    end
    check_eq("rvalid", 32'(rvalid_o), 32'(exp_v));
    if (have) begin
      for (int k = 0; k < N; k++) begin
        if (k == e.m) begin
          check_eq("err", 32'(err_o[k]), 32'(e.err));
          if (e.known) check_eq("rdata", rdata_o[k*32 +: 32], e.data);
          obs_rdata[k] = rdata_o[k*32 +: 32];
          obs_err[k]   = err_o[k];
          obs_vld[k]   = rvalid_o[k];
        end
      end
    end
    check_eq("passed", 32'(tests_passed_o), 32'(m_pass));
    check_eq("failed", 32'(tests_failed_o), 32'(m_fail));
    check_eq("exit_valid", 32'(exit_valid_o), 32'(m_exv));
    check_eq("exit_value", exit_value_o, m_exit);

    req_i = d_req;
    for (int k = 0; k < N; k++) begin
      addr_i[k*32 +: 32]  = d_addr[k];
      we_i[k]             = d_we[k];
      be_i[k*4 +: 4]      = d_be[k];
      wdata_i[k*32 +: 32] = d_wdata[k];
    end
    #1;
    // Winner = requester with the smallest rotated distance from the pointer.
    best = -1; bestd = N;
    for (int k = 0; k < N; k++) begin
      if (d_req[k]) begin
        int dd;
        dd = (k - rr + N) % N;
        if (dd < bestd) begin bestd = dd; best = k; end
      end
    end
    check_eq("gnt", 32'(gnt_o), (best < 0) ? 32'h0 : 32'(1 << best));
    obs_gnt = gnt_o;
    if (best >= 0) begin
      rr = (best + 1) % N;
      model_apply(best);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i  = '0;
    #1;
    check_eq("rst_gnt", 32'(gnt_o), 32'h0);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
    check_eq("rst_err", 32'(err_o), 32'h0);
    check_eq("rst_rdata0", rdata_o[31:0], 32'h0);
    check_eq("rst_rdata1", rdata_o[63:32], 32'h0);
    check_eq("rst_rdata2", rdata_o[95:64], 32'h0);
    check_eq("rst_flags", {28'h0, tests_passed_o, tests_failed_o, exit_valid_o, 1'b0}, 32'h0);
    check_eq("rst_exit", exit_value_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    q.delete();
    rr = 0; m_pass = 0; m_fail = 0; m_exv = 0; m_exit = 0;
    cyc += 3;
  endtask

  task automatic idle_steps(input int n);
    set_idle();
    repeat (n) step();
  endtask

  task automatic rand_op(input int k);
    int sel;
    sel = $urandom_range(0, 19);
    d_we[k]    = 1'($urandom_range(0, 1));
    d_be[k]    = 4'($urandom);
    d_wdata[k] = $urandom;
    if (sel < 15)       d_addr[k] = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    else if (sel == 15) d_addr[k] = 32'h3000_0000;
    else if (sel == 16) d_addr[k] = 32'(DEPTH * 4);
    else if (sel == 17) begin
      d_addr[k] = TS;
      if ($urandom_range(0, 1) == 0) d_wdata[k] = 32'd123456789;
      else if ($urandom_range(0, 3) == 0) d_wdata[k] = 32'd1;
    end
    else if (sel == 18) d_addr[k] = EX;
    else                d_addr[k] = 32'h2000_0008;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    set_idle();
    clear_obs();
    do_reset();

    // Scenario 1: write then read back through master 0.
    d_req = 3'b001; d_addr[0] = 32'h10; d_we[0] = 1; d_be[0] = 4'hF; d_wdata[0] = 32'hDEADBEEF;
    step();
    check_eq("t1_gnt_wr", 32'(obs_gnt), 32'h1);
    d_we[0] = 0;
    step();
    check_eq("t1_gnt_rd", 32'(obs_gnt), 32'h1);
    clear_obs();
    idle_steps(3);
    check_eq("t1_rdata", obs_rdata[0], 32'hDEADBEEF);
    check_eq("t1_err", 32'(obs_err[0]), 32'h0);

    // Master 2 takes one grant so the search restarts at master 0.
    d_req = 3'b100; d_addr[2] = 32'h10;
    step();
    idle_steps(3);

    // Scenario 2: all three request continuously.
    d_req = 3'b111;
    for (int k = 0; k < N; k++) d_addr[k] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t2_gnt", 32'(obs_gnt), 32'(seq[i]));
    end
    idle_steps(3);

    // Scenario 3: partial byte-enable write.
    d_req = 3'b010; d_addr[1] = 32'h20; d_we[1] = 1; d_be[1] = 4'hF; d_wdata[1] = 32'h11223344;
    step();
    d_be[1] = 4'b0101; d_wdata[1] = 32'hAABBCCDD;
    step();
    d_we[1] = 0;
    step();
    clear_obs();
    idle_steps(3);
    check_eq("t3_rdata", obs_rdata[1], 32'h11BB33DD);

    // Scenario 4: pseudo-peripherals.
    set_idle();
    d_req = 3'b010; d_addr[1] = TS; d_we[1] = 1; d_wdata[1] = 32'd123456789;
    step();
    idle_steps(1);
    check_eq("t4_pass", 32'(tests_passed_o), 32'h1);
    check_eq("t4_fail", 32'(tests_failed_o), 32'h0);
    d_req = 3'b100; d_addr[2] = EX; d_we[2] = 1; d_wdata[2] = 32'd7;
    step();
    idle_steps(1);
    check_eq("t4_exit_val", exit_value_o, 32'd7);
    check_eq("t4_exit_vld", 32'(exit_valid_o), 32'h1);

    // Scenario 5: unmapped address.
    d_req = 3'b001; d_addr[0] = 32'h3000_0000; d_we[0] = 0;
    step();
    clear_obs();
    idle_steps(3);
    check_eq("t5_err", 32'(obs_err[0]), 32'h1);
    check_eq("t5_rdata", obs_rdata[0], 32'h0);
    check_eq("t5_pass_kept", 32'(tests_passed_o), 32'h1);
    check_eq("t5_exit_kept", exit_value_o, 32'd7);

    // Scenario 6: reset while a read is in flight.
    d_req = 3'b010; d_addr[1] = 32'h10; d_we[1] = 0;
    step();
    set_idle();
    clear_obs();
    do_reset();
    idle_steps(4);
    check_eq("t6_no_rvalid", 32'(obs_vld[1]), 32'h0);
    d_req = 3'b001; d_addr[0] = 32'h10;
    step();
    clear_obs();
    idle_steps(3);
    check_eq("t6_ram_kept", obs_rdata[0], 32'hDEADBEEF);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        d_req[k] = ($urandom_range(0, 9) < 6);
        rand_op(k);
      end
      step();
      if (i == 200) begin
        set_idle();
        do_reset();
      end
    end
    idle_steps(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
